// File: rtl/menu_pkg.sv
// rtl/menu_pkg.sv - shared states and BMP header constants for the bitmap loader
package menu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PIXELS,
    ST_DRAIN,
    ST_ERROR
  } state_t;

  localparam logic [7:0]  BMP_SIG0       = 8'h42;
  localparam logic [7:0]  BMP_SIG1       = 8'h4D;
  localparam logic [24:0] HDR_DATA_START = 25'd10;
  localparam logic [24:0] HDR_WIDTH      = 25'd18;
  localparam logic [24:0] HDR_HEIGHT     = 25'd22;
  localparam logic [24:0] HDR_BPP        = 25'd28;
  localparam logic [24:0] HDR_MIN_DATA   = 25'd30;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; simultaneous push and pop is legal even when full
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bmp_stream_loader.sv
// rtl/bmp_stream_loader.sv - parses a downloaded BMP and streams its pixel bytes to SRAM
module bmp_stream_loader
  import menu_pkg::*;
#(
  parameter int ADDR_WIDTH = 19,
  parameter int FIFO_DEPTH = 4,
  parameter int REQ_BPP    = 32
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  output logic                  mem_wr_req,
  input  logic                  mem_wr_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic [23:0]           data_start,
  output logic [15:0]           bmp_width,
  output logic [15:0]           bmp_height,
  output logic                  bmp_loaded,
  output logic                  bmp_error
);

  localparam int          FW        = ADDR_WIDTH + 8;
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] REQ_BPP16 = 16'(REQ_BPP);

  state_t state, state_next;

  logic          wr_q, dl_q;
  logic          take, dl_rise, dl_fall;
  logic [7:0]    bpp_lo;
  logic [24:0]   ds_ext, pix_off;
  logic          in_range, hdr_bad;
  logic          hdr_clear, want_push, set_err, set_loaded;
  logic          f_push, f_pop, f_full, f_empty;
  logic [CW-1:0] f_count;
  logic [FW-1:0] f_din, f_head;

  assign take    = ioctl_wr & ~wr_q & ioctl_download;
  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;

  // Offset arithmetic stays 25-bit so the range check sees the full difference.
  assign ds_ext   = {1'b0, data_start};
  assign pix_off  = ioctl_addr - ds_ext;
  assign in_range = (ioctl_addr >= ds_ext) && ((pix_off >> ADDR_WIDTH) == 25'd0);
  assign f_din    = {pix_off[ADDR_WIDTH-1:0], ioctl_dout};
  assign f_pop    = mem_wr_ack & ~f_empty;

  assign hdr_bad = ((ioctl_addr == 25'd0) && (ioctl_dout != BMP_SIG0))
                || ((ioctl_addr == 25'd1) && (ioctl_dout != BMP_SIG1))
                || ((ioctl_addr == HDR_BPP + 25'd1) && ({ioctl_dout, bpp_lo} != REQ_BPP16))
                || ((ioctl_addr > HDR_DATA_START + 25'd2) && (ds_ext < HDR_MIN_DATA));

  always_comb begin
    state_next = state;
    hdr_clear  = 1'b0;
    want_push  = 1'b0;
    set_err    = 1'b0;
    set_loaded = 1'b0;
    f_push     = 1'b0;
    if (dl_rise) begin
      state_next = ST_HEADER;
      hdr_clear  = 1'b1;
    end else begin
      case (state)
        ST_HEADER: begin
          if (dl_fall) begin
            state_next = ST_IDLE;
          end else if (take) begin
            if (hdr_bad) begin
              set_err    = 1'b1;
              state_next = ST_ERROR;
            end else if ((ioctl_addr > HDR_DATA_START + 25'd2) && (ioctl_addr >= ds_ext)) begin
              state_next = ST_PIXELS;
              want_push  = in_range;
            end
          end
        end
        ST_PIXELS: begin
          if (dl_fall)                 state_next = ST_DRAIN;
          else if (take && in_range)   want_push  = 1'b1;
        end
        ST_DRAIN: begin
          if (f_count == '0) begin
            set_loaded = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_ERROR: begin
          if (dl_fall) state_next = ST_IDLE;
        end
        default: state_next = state;
      endcase
    end
    // A pop in the same cycle frees a slot, so only a push onto a full, non-draining queue overflows.
    if (want_push && f_full && !f_pop) begin
      set_err    = 1'b1;
      state_next = ST_ERROR;
    end else begin
      f_push = want_push;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      wr_q       <= 1'b0;
      dl_q       <= 1'b0;
      bpp_lo     <= '0;
      data_start <= '0;
      bmp_width  <= '0;
      bmp_height <= '0;
      bmp_loaded <= 1'b0;
      bmp_error  <= 1'b0;
    end else begin
      state <= state_next;
      wr_q  <= ioctl_wr;
      dl_q  <= ioctl_download;
      if (hdr_clear) begin
        bpp_lo     <= '0;
        data_start <= '0;
        bmp_width  <= '0;
        bmp_height <= '0;
        bmp_loaded <= 1'b0;
        bmp_error  <= 1'b0;
      end else begin
        if (set_err)    bmp_error  <= 1'b1;
        if (set_loaded) bmp_loaded <= 1'b1;
        if (state == ST_HEADER && take) begin
          case (ioctl_addr)
            HDR_DATA_START:          data_start[7:0]   <= ioctl_dout;
            HDR_DATA_START + 25'd1:  data_start[15:8]  <= ioctl_dout;
            HDR_DATA_START + 25'd2:  data_start[23:16] <= ioctl_dout;
            HDR_WIDTH:               bmp_width[7:0]    <= ioctl_dout;
            HDR_WIDTH + 25'd1:       bmp_width[15:8]   <= ioctl_dout;
            HDR_HEIGHT:              bmp_height[7:0]   <= ioctl_dout;
            HDR_HEIGHT + 25'd1:      bmp_height[15:8]  <= ioctl_dout;
            HDR_BPP:                 bpp_lo            <= ioctl_dout;
            default:                 ;
          endcase
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .clr       (hdr_clear),
    .push      (f_push),
    .push_data (f_din),
    .pop       (f_pop),
    .pop_data  (f_head),
    .full      (f_full),
    .empty     (f_empty),
    .count     (f_count)
  );

  // Head is gated so the write port reads all-zero whenever nothing is offered.
  assign mem_wr_req = ~f_empty;
  assign mem_addr   = f_empty ? '0 : f_head[FW-1:8];
  assign mem_data   = f_empty ? '0 : f_head[7:0];

endmodule
